// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: receive-side monitor for a 4-digit multiplexed,
// active-low seven-segment display. It registers the anode/segment pins,
// qualifies each digit dwell by stability and decodes the pattern back to a
// hex nibble. Once all four digits have been captured, it publishes them as a
// 16-bit frame.
// Optional build macro: SEG7_CHANGE_ONLY_EN. When defined, a completed frame
// is published only if it differs from the frame currently held.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  AN,
    input  logic [6:0]  segs,
    output logic [15:0] value,
    output logic [3:0]  blank_mask,
    output logic [3:0]  invalid_mask,
    output logic        frame_valid,
    output logic        multi_an_err,
    output logic        timeout
);

    localparam logic [7:0]  STABLE_L  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {ST_WAIT = 1'b0, ST_HELD = 1'b1} state_t;

    // Decode an active-low segment pattern to {blank, invalid, nibble}.
    // Blank and unknown patterns both decode to nibble 0.
    function automatic logic [5:0] seg_decode(input logic [6:0] segs_n);
        logic [6:0] lit;
        lit = ~segs_n;
        case (lit)
            7'h00:   seg_decode = {1'b1, 1'b0, 4'h0};
            7'h3F:   seg_decode = {1'b0, 1'b0, 4'h0};
            7'h06:   seg_decode = {1'b0, 1'b0, 4'h1};
            7'h5B:   seg_decode = {1'b0, 1'b0, 4'h2};
            7'h4F:   seg_decode = {1'b0, 1'b0, 4'h3};
            7'h66:   seg_decode = {1'b0, 1'b0, 4'h4};
            7'h6D:   seg_decode = {1'b0, 1'b0, 4'h5};
            7'h7D:   seg_decode = {1'b0, 1'b0, 4'h6};
            7'h07:   seg_decode = {1'b0, 1'b0, 4'h7};
            7'h7F:   seg_decode = {1'b0, 1'b0, 4'h8};
            7'h6F:   seg_decode = {1'b0, 1'b0, 4'h9};
            7'h77:   seg_decode = {1'b0, 1'b0, 4'hA};
            7'h7C:   seg_decode = {1'b0, 1'b0, 4'hB};
            7'h39:   seg_decode = {1'b0, 1'b0, 4'hC};
            7'h5E:   seg_decode = {1'b0, 1'b0, 4'hD};
            7'h79:   seg_decode = {1'b0, 1'b0, 4'hE};
            7'h71:   seg_decode = {1'b0, 1'b0, 4'hF};
            default: seg_decode = {1'b0, 1'b1, 4'h0};
        endcase
    endfunction

    logic [3:0]  an_q, an_prev_q;
    logic [6:0]  segs_q, segs_prev_q;
    logic [7:0]  run_q, run_d;
    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] dig_nib_q, dig_nib_d;
    logic [3:0]  dig_blank_q, dig_blank_d;
    logic [3:0]  dig_inv_q, dig_inv_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  blank_mask_q, blank_mask_d;
    logic [3:0]  invalid_mask_q, invalid_mask_d;
    logic        frame_valid_q, frame_valid_d;
    logic        multi_an_err_q, multi_an_err_d;
    logic        timeout_q, timeout_d;

    logic        sample_chg_s, qualify_s, single_s, multi_s, capture_s;
    logic        tmo_active_s, tmo_fire_s, complete_s, publish_s;
    logic [1:0]  idx_s;
    logic [5:0]  dec_s;
    logic [3:0]  mask_base_s;
    logic [15:0] tmo_inc_s;

    // Next-state logic: run counter, dwell FSM, capture, frame assembly, timeout.
    always_comb begin
        sample_chg_s = (an_q != an_prev_q) || (segs_q != segs_prev_q);

        if (sample_chg_s) begin
            run_d = 8'd1;
        end else if (run_q >= STABLE_L) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 8'd1;
        end

        // A dwell is qualified on the cycle its run counter reaches the
        // threshold, and only once: HELD ignores it until the sample changes.
        qualify_s = 1'b0;
        state_d   = state_q;
        case (state_q)
            ST_WAIT: begin
                if (run_d == STABLE_L) begin
                    qualify_s = 1'b1;
                    state_d   = ST_HELD;
                end else begin
                    state_d   = ST_WAIT;
                end
            end
            ST_HELD: begin
                if (sample_chg_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        single_s = 1'b1;
        idx_s    = 2'd0;
        case (an_q)
            4'b1110: idx_s = 2'd0;
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: single_s = 1'b0;
        endcase
        multi_s   = !single_s && (an_q != 4'b1111);
        capture_s = qualify_s && single_s;
        dec_s     = seg_decode(segs_q);

        tmo_inc_s    = tmo_q + 16'd1;
        tmo_active_s = (mask_q != 4'b0000) && (mask_q != 4'b1111);
        tmo_fire_s   = tmo_active_s && (tmo_inc_s == TIMEOUT_L);
        complete_s   = (mask_q == 4'b1111);

`ifdef SEG7_CHANGE_ONLY_EN
        publish_s = complete_s &&
                    ({dig_nib_q, dig_blank_q, dig_inv_q} !=
                     {value_q, blank_mask_q, invalid_mask_q});
`else
        publish_s = complete_s;
`endif

        value_d        = value_q;
        blank_mask_d   = blank_mask_q;
        invalid_mask_d = invalid_mask_q;
        frame_valid_d  = 1'b0;
        timeout_d      = 1'b0;
        multi_an_err_d = qualify_s && multi_s;

        if (publish_s) begin
            value_d        = dig_nib_q;
            blank_mask_d   = dig_blank_q;
            invalid_mask_d = dig_inv_q;
            frame_valid_d  = 1'b1;
        end else begin
            frame_valid_d  = 1'b0;
        end

        if (complete_s || tmo_fire_s) begin
            mask_base_s = 4'b0000;
            timeout_d   = tmo_fire_s;
        end else begin
            mask_base_s = mask_q;
        end

        // A capture coinciding with a timeout is dropped.
        dig_nib_d   = dig_nib_q;
        dig_blank_d = dig_blank_q;
        dig_inv_d   = dig_inv_q;
        if (capture_s && !tmo_fire_s) begin
            dig_nib_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
            dig_blank_d[idx_s]             = dec_s[5];
            dig_inv_d[idx_s]               = dec_s[4];
            mask_d = mask_base_s | (4'b0001 << idx_s);
        end else begin
            mask_d = mask_base_s;
        end

        if (tmo_active_s && !tmo_fire_s) begin
            tmo_d = tmo_inc_s;
        end else begin
            tmo_d = 16'd0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q           <= 4'hF;
            segs_q         <= 7'h7F;
            an_prev_q      <= 4'hF;
            segs_prev_q    <= 7'h7F;
            run_q          <= 8'd0;
            state_q        <= ST_WAIT;
            mask_q         <= 4'b0000;
            tmo_q          <= 16'd0;
            dig_nib_q      <= 16'h0000;
            dig_blank_q    <= 4'b0000;
            dig_inv_q      <= 4'b0000;
            value_q        <= 16'h0000;
            blank_mask_q   <= 4'b0000;
            invalid_mask_q <= 4'b0000;
            frame_valid_q  <= 1'b0;
            multi_an_err_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            an_q           <= AN;
            segs_q         <= segs;
            an_prev_q      <= an_q;
            segs_prev_q    <= segs_q;
            run_q          <= run_d;
            state_q        <= state_d;
            mask_q         <= mask_d;
            tmo_q          <= tmo_d;
            dig_nib_q      <= dig_nib_d;
            dig_blank_q    <= dig_blank_d;
            dig_inv_q      <= dig_inv_d;
            value_q        <= value_d;
            blank_mask_q   <= blank_mask_d;
            invalid_mask_q <= invalid_mask_d;
            frame_valid_q  <= frame_valid_d;
            multi_an_err_q <= multi_an_err_d;
            timeout_q      <= timeout_d;
        end
    end

    assign value        = value_q;
    assign blank_mask   = blank_mask_q;
    assign invalid_mask = invalid_mask_q;
    assign frame_valid  = frame_valid_q;
    assign multi_an_err = multi_an_err_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans, a reference
// decoder and a frame scoreboard (expected frames queued as scans are driven,
// compared as frame_valid pulses are observed).
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  AN = 4'hF;
    logic [6:0]  segs = 7'h7F;
    logic [15:0] value;
    logic [3:0]  blank_mask, invalid_mask;
    logic        frame_valid, multi_an_err, timeout;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .AN(AN), .segs(segs),
        .value(value), .blank_mask(blank_mask), .invalid_mask(invalid_mask),
        .frame_valid(frame_valid), .multi_an_err(multi_an_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor (sampled on the falling edge)
    int          fv_count = 0, mae_count = 0, tmo_count = 0, tmo_cyc = 0;
    logic [15:0] obs_val   [64];
    logic [3:0]  obs_blank [64];
    logic [3:0]  obs_inv   [64];
    int          obs_cyc   [64];
    always @(negedge clk) begin
        if (frame_valid) begin
            obs_val[fv_count]   <= value;
            obs_blank[fv_count] <= blank_mask;
            obs_inv[fv_count]   <= invalid_mask;
            obs_cyc[fv_count]   <= cyc;
            fv_count            <= fv_count + 1;
        end
        if (multi_an_err) mae_count <= mae_count + 1;
        if (timeout) begin
            tmo_count <= tmo_count + 1;
            tmo_cyc   <= cyc;
        end
    end

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  i;
    } frame_t;

    frame_t exp_q[$];
    frame_t m_held;
    logic [3:0] m_nib [4];
    logic [3:0] m_blank, m_inv, m_mask;
    int checks = 0, errors = 0, consumed = 0, last_start = 0;

    // Lit-segment patterns (bit0 = a) for hex digits 0..F
    localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
        7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_capture(input int d, input logic [6:0] sg);
        logic [6:0] lit;
        frame_t f;
        lit = ~sg;
        m_nib[d]   = 4'h0;
        m_blank[d] = (sg == 7'h7F);
        m_inv[d]   = !m_blank[d];
        for (int k = 0; k < 16; k++) begin
            if (!m_blank[d] && lit == LIT[k]) begin
                m_nib[d] = 4'(k);
                m_inv[d] = 1'b0;
            end
        end
        m_mask[d] = 1'b1;
        if (m_mask == 4'b1111) begin
            f.v = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            f.b = m_blank;
            f.i = m_inv;
            m_mask = 4'b0000;
`ifdef SEG7_CHANGE_ONLY_EN
            if (f != m_held) begin
                exp_q.push_back(f);
                m_held = f;
            end
`else
            exp_q.push_back(f);
            m_held = f;
`endif
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int hold);
        AN = an;
        segs = sg;
        last_start = cyc;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int d, input logic [6:0] sg, input int hold);
        drive(~(4'b0001 << d), sg, hold);
        if (hold >= STABLE) model_capture(d, sg);
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        digit(0, s0, 8);
        digit(1, s1, 8);
        digit(2, s2, 8);
        digit(3, s3, 8);
    endtask

    task automatic check_frames(input string tag);
        frame_t f;
        int n = 0;
        while (fv_count < consumed + exp_q.size() && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            if (consumed < fv_count) begin
                chk({tag, "_value"}, 32'(obs_val[consumed]), 32'(f.v));
                chk({tag, "_blank"}, 32'(obs_blank[consumed]), 32'(f.b));
                chk({tag, "_inv"},   32'(obs_inv[consumed]), 32'(f.i));
                consumed++;
            end else begin
                chk({tag, "_missing_frame"}, 32'(fv_count), 32'(consumed + 1));
            end
        end
        chk({tag, "_frame_count"}, 32'(fv_count), 32'(consumed));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, mae0, fv0, n, d0_start, d3_start;
        m_held = '0;
        m_mask = 4'b0000;
        m_blank = 4'b0000;
        m_inv = 4'b0000;
        for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;

        // Reset with toggling pins
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            AN = 4'($urandom_range(0, 15));
            segs = 7'($urandom_range(0, 127));
            @(negedge clk);
            chk("reset_outputs", {value, blank_mask, invalid_mask, frame_valid, multi_an_err, timeout}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 10);
        chk("post_reset_no_frame", 32'(fv_count), 32'd0);
        chk("post_reset_no_err", 32'(mae_count + tmo_count), 32'd0);

        // Normal scan 0,1,2,3 with latency check on digit 3
        idx = consumed;
        digit(0, 7'h40, 8);
        digit(1, 7'h79, 8);
        digit(2, 7'h24, 8);
        drive(4'b0111, 7'h30, 8);
        d3_start = last_start;
        model_capture(3, 7'h30);
        drive(4'hF, 7'h7F, 2);
        check_frames("normal");
        chk("normal_latency", 32'(obs_cyc[idx] - d3_start), 32'(STABLE + 2));
        chk("normal_no_mae", 32'(mae_count), 32'd0);

        // Glitched digit 3 -> partial frame, then timeout
        drive(4'b1110, 7'h40, 8);
        d0_start = last_start;
        model_capture(0, 7'h40);
        drive(4'hF, 7'h7F, 2);
        digit(1, 7'h79, 8);
        digit(2, 7'h24, 8);
        digit(3, 7'h30, 3);
        n = 0;
        while (tmo_count == 0 && n < TMO + 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        m_mask = 4'b0000;
        chk("glitch_timeout_count", 32'(tmo_count), 32'd1);
        chk("glitch_timeout_time", 32'(tmo_cyc - d0_start), 32'(STABLE + 1 + TMO));
        chk("glitch_value_held", 32'(value), 32'(m_held.v));
        check_frames("glitch");

        // Multi-anode dwell, then blank / invalid / valid digits
        mae0 = mae_count;
        drive(4'b1100, 7'h40, 12);
        drive(4'hF, 7'h7F, 4);
        chk("multi_an_pulses", 32'(mae_count - mae0), 32'd1);
        scan4(7'h7F, 7'h7F, 7'h7E, 7'h19);
        check_frames("errpat");
        chk("errpat_value_pin", 32'(value), 32'(m_held.v));
        chk("errpat_masks_pin", 32'({blank_mask, invalid_mask}), 32'({m_held.b, m_held.i}));

        // Two identical scans
        fv0 = fv_count;
        scan4(7'h40, 7'h79, 7'h24, 7'h30);
        scan4(7'h40, 7'h79, 7'h24, 7'h30);
        check_frames("repeat");
`ifdef SEG7_CHANGE_ONLY_EN
        chk("repeat_pulses", 32'(fv_count - fv0), 32'd1);
`else
        chk("repeat_pulses", 32'(fv_count - fv0), 32'd2);
`endif

        // Reset in the middle of a scan
        scan4(7'h06 ^ 7'h7F, 7'h40, 7'h40, 7'h40);
        check_frames("pre_mid");
        digit(0, 7'h40, 8);
        digit(1, 7'h79, 8);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_mask = 4'b0000;
        m_held = '0;
        chk("mid_reset_value", 32'(value), 32'(m_held.v));
        digit(2, 7'h24, 8);
        digit(3, 7'h30, 8);
        check_frames("mid_partial");
        scan4(7'h40, 7'h79, 7'h24, 7'h30);
        check_frames("mid_full");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
